mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port unified instruction/data RAM between the fetch path (PC-addressed reads) and the load/store path (ALU-addressed reads/writes).
- Sits between the core datapath and the RAM; replaces the separate instruction and data memories once the core moves to a unified memory.
- Arbitrates with data-priority plus an anti-starvation counter for fetch.
- Sequences read latency and returns read data to the owning requester.

Parameters:
- ADDR_W, 32, address width of both requesters and memory
- DATA_W, 32, data width; strobe width is DATA_W/8
- MEM_LAT, 1, RAM read latency in cycles (>=1), from mem_en_o to valid mem_rdata_i
- MAX_WAIT, 4, consecutive lost fetch arbitrations before fetch is forced to win (>=1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch read request
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch read data valid (1-cycle pulse)
- if_rdata_o  out  DATA_W  fetch read data
- d_req_i  in  1  data request
- d_we_i  in  1  1 = write, 0 = read
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  write data
- d_strb_i  in  DATA_W/8  byte write strobes
- d_gnt_o  out  1  data request accepted this cycle
- d_rvalid_o  out  1  data read data valid (1-cycle pulse)
- d_rdata_o  out  DATA_W  data read data
- mem_en_o  out  1  RAM access strobe
- mem_we_o  out  1  RAM write enable
- mem_addr_o  out  ADDR_W  RAM address
- mem_wdata_o  out  DATA_W  RAM write data
- mem_strb_o  out  DATA_W/8  RAM byte strobes
- mem_rdata_i  in  DATA_W  RAM read data

Behaviour:
- Reset:
  - reset low forces state IDLE, starvation count 0, owner none.
  - All gnt/rvalid/mem_en_o/mem_we_o are 0 while reset is low.
  - rdata outputs are 0.
- Request protocol:
  - A requester holds req and its address/data/strobes stable until the cycle it sees gnt.
  - gnt is combinational; it is asserted in the same cycle the access is driven onto mem_*.
- Port mux: mem_addr_o, mem_wdata_o, mem_strb_o and mem_we_o come from the winner. mem_we_o is 0 for a fetch.
- FSM states:
  - IDLE: may grant.
    - Data write: completes in the grant cycle; stays IDLE; the next grant can happen on the next cycle.
    - Read (either port): latches owner, loads the latency counter with MEM_LAT, goes to WAIT.
  - WAIT: no grants. The counter decrements each cycle. When it reaches 1 (i.e. at grant cycle + MEM_LAT):
    - the owner's rvalid pulses and rdata = mem_rdata_i (registered onto the rdata output that cycle);
    - the state returns to IDLE, and a new grant may be issued in that same cycle.
  - Read throughput: one read per MEM_LAT cycles.
- Arbitration (IDLE only):
  - Data wins over fetch, unless the starvation count == MAX_WAIT; then fetch wins.
  - The starvation count increments (saturating at MAX_WAIT) each IDLE cycle in which if_req_i=1 and data wins.
  - The count clears on any fetch grant, and clears in any cycle with if_req_i=0.
- Simultaneous events:
  - If only one port requests, it wins regardless of the count.
  - rvalid and a new gnt in the same cycle are legal.
  - The non-owner's rvalid is never asserted.
- Reset mid-read: a pending rvalid is dropped and never issued after reset deasserts.
- if_rdata_o and d_rdata_o hold their last value when rvalid is 0.

Decomposition:
- Shared package:
  - state enum (IDLE, WAIT);
  - owner encoding (OWN_NONE, OWN_IF, OWN_D);
  - default MEM_LAT and MAX_WAIT constants shared with the top level.
- One sub-module, arb_starve_ctr: the saturating starvation counter, with inputs inc, clr and output at_max.
- FSM, latency counter and mux stay in mem_arbiter.

Test Plan:
- Reset with both requests high -> no gnt, mem_en_o=0. After release: d_gnt_o=1 first (count 0).
- MEM_LAT=2; fetch read to 0x100, RAM returns 0xDEADBEEF -> if_gnt_o at T, if_rvalid_o=1 at T+2 with 0xDEADBEEF. No grant at T+1; a new grant is allowed at T+2.
- Continuous d_req_i writes plus if_req_i, MAX_WAIT=4 -> data is granted 4 times, then fetch is granted on the 5th IDLE cycle, then data resumes.
- Data write 0x0000_00AA, strb 4'b0001 to 0x40 -> mem_we_o=1, mem_strb_o=0001 in the grant cycle. d_rvalid_o is never asserted; back-to-back writes are granted every cycle.
- Data read granted, reset pulsed low at T+1 (MEM_LAT=2) -> no d_rvalid_o at T+2 or later; count 0; next request is granted normally.
- Fetch read with rvalid in the same cycle as a new data-read grant -> if_rvalid_o and d_gnt_o are both 1 that cycle. d_rvalid_o arrives MEM_LAT cycles later with the correct data.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the unified-memory arbiter: FSM states, owner codes, default timing.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    localparam int DEF_MEM_LAT  = 1;
    localparam int DEF_MAX_WAIT = 4;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive fetch arbitration losses; at_max forces fetch to win.
// Latency: count updates on the clock edge after inc/clr; at_max is a direct decode.
// Backpressure: none; clr has priority over inc.
module arb_starve_ctr
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int            CNT_W = cnt_w(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign at_max = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between fetch reads and load/store accesses (data priority, fetch anti-starvation).
// Latency: grant is combinational; read data returns MEM_LAT cycles after grant, writes finish in the grant cycle.
// Backpressure: requesters hold req until gnt; no grants while a read is outstanding, except in its return cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = DEF_MEM_LAT,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,

    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_strb_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,

    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_strb_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int               LAT_W    = cnt_w(MEM_LAT);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(1);

    logic              state_q;
    logic [1:0]        owner_q;
    logic [LAT_W-1:0]  lat_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic starve_max;
    logic rsp_fire;
    logic can_grant;
    logic if_win;
    logic d_win;
    logic rd_grant;

    // The return cycle of a read reopens arbitration so reads can issue every MEM_LAT cycles.
    assign rsp_fire  = (state_q == ST_WAIT) && (lat_q == LAT_LAST);
    assign can_grant = reset && ((state_q == ST_IDLE) || rsp_fire);

    assign if_win   = can_grant && if_req_i && (!d_req_i || starve_max);
    assign d_win    = can_grant && d_req_i && !if_win;
    assign rd_grant = if_win || (d_win && !d_we_i);

    assign if_gnt_o = if_win;
    assign d_gnt_o  = d_win;

    assign mem_en_o    = if_win || d_win;
    assign mem_we_o    = d_win && d_we_i;
    assign mem_addr_o  = if_win ? if_addr_i : d_addr_i;
    assign mem_wdata_o = d_win ? d_wdata_i : '0;
    assign mem_strb_o  = d_win ? d_strb_i : '0;

    assign if_rvalid_o = rsp_fire && (owner_q == OWN_IF);
    assign d_rvalid_o  = rsp_fire && (owner_q == OWN_D);

    // Return data passes straight through on the valid cycle and is held afterwards.
    assign if_rdata_o = if_rvalid_o ? mem_rdata_i : if_rdata_q;
    assign d_rdata_o  = d_rvalid_o  ? mem_rdata_i : d_rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_NONE;
            lat_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (if_rvalid_o) begin
                if_rdata_q <= mem_rdata_i;
            end
            if (d_rvalid_o) begin
                d_rdata_q <= mem_rdata_i;
            end

            if (rd_grant) begin
                state_q <= ST_WAIT;
                owner_q <= if_win ? OWN_IF : OWN_D;
                lat_q   <= LAT_LOAD;
            end else if (rsp_fire) begin
                state_q <= ST_IDLE;
                owner_q <= OWN_NONE;
                lat_q   <= '0;
            end else if (state_q == ST_WAIT) begin
                lat_q <= lat_q - LAT_LAST;
            end
        end
    end

    // Losses count only when fetch is actually waiting; idle fetch or a fetch grant resets the run.
    arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (d_win && if_req_i),
        .clr    (!if_req_i || if_win),
        .at_max (starve_max)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter with a RAM model and a queue-based reference.
// Reference tracks the free cycle, fetch loss streak and outstanding reads per requester.
module tb_mem_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int STRB_W   = DATA_W / 8;
    localparam int MEM_LAT  = 2;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [STRB_W-1:0] d_strb_i;
    logic              d_gnt_o;
    logic              d_rvalid_o;
    logic [DATA_W-1:0] d_rdata_o;
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [STRB_W-1:0] mem_strb_o;
    logic [DATA_W-1:0] mem_rdata_i;

    mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MEM_LAT  (MEM_LAT),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_strb_i    (d_strb_i),
        .d_gnt_o     (d_gnt_o),
        .d_rvalid_o  (d_rvalid_o),
        .d_rdata_o   (d_rdata_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_strb_o  (mem_strb_o),
        .mem_rdata_i (mem_rdata_i)
    );

    // RAM with a two-stage read pipeline, driven only by the DUT's mem_* port.
    logic [DATA_W-1:0] ram [0:127];
    logic [DATA_W-1:0] ram_p1;
    logic [DATA_W-1:0] ram_p2;
    logic              ram_clr;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 128; i++) ram[i] <= '0;
        end else if (mem_en_o && mem_we_o) begin
            for (int b = 0; b < STRB_W; b++)
                if (mem_strb_o[b]) ram[mem_addr_o[8:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
        if (mem_en_o && !mem_we_o) ram_p1 <= ram[mem_addr_o[8:2]];
        ram_p2 <= ram_p1;
    end
    assign mem_rdata_i = ram_p2;

    typedef struct {
        int                due;
        bit                is_if;
        logic [DATA_W-1:0] data;
    } rsp_t;

    rsp_t              pending[$];
    logic [DATA_W-1:0] ref_mem [0:127];
    logic [DATA_W-1:0] last_if_rd;
    logic [DATA_W-1:0] last_d_rd;
    int                cyc;
    int                next_free;
    int                losses;
    int                n_tests;
    int                n_fail;

    bit                obs_ig, obs_dg, obs_irv, obs_drv, obs_we;
    logic [DATA_W-1:0] obs_ird, obs_drd;
    logic [STRB_W-1:0] obs_strb;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_cycle();
        bit                free, eig, edg, eirv, edrv;
        logic [DATA_W-1:0] erd;
        logic [6:0]        ridx;
        obs_ig   = if_gnt_o;
        obs_dg   = d_gnt_o;
        obs_irv  = if_rvalid_o;
        obs_drv  = d_rvalid_o;
        obs_we   = mem_we_o;
        obs_ird  = if_rdata_o;
        obs_drd  = d_rdata_o;
        obs_strb = mem_strb_o;
        if (!reset) begin
            chk("rst_if_gnt",    if_gnt_o,    0);
            chk("rst_d_gnt",     d_gnt_o,     0);
            chk("rst_mem_en",    mem_en_o,    0);
            chk("rst_mem_we",    mem_we_o,    0);
            chk("rst_if_rvalid", if_rvalid_o, 0);
            chk("rst_d_rvalid",  d_rvalid_o,  0);
            chk("rst_if_rdata",  if_rdata_o,  0);
            chk("rst_d_rdata",   d_rdata_o,   0);
            pending.delete();
            losses     = 0;
            next_free  = 0;
            last_if_rd = '0;
            last_d_rd  = '0;
            cyc++;
            return;
        end

        free = (cyc >= next_free);
        eig  = free && if_req_i && (!d_req_i || losses == MAX_WAIT);
        edg  = free && d_req_i && !eig;
        chk("if_gnt", if_gnt_o, eig);
        chk("d_gnt",  d_gnt_o,  edg);
        chk("mem_en", mem_en_o, eig || edg);
        if (eig) begin
            chk("if_mem_addr", mem_addr_o, if_addr_i);
            chk("if_mem_we",   mem_we_o,   0);
        end
        if (edg) begin
            chk("d_mem_addr", mem_addr_o, d_addr_i);
            chk("d_mem_we",   mem_we_o,   d_we_i);
            if (d_we_i) begin
                chk("d_mem_wdata", mem_wdata_o, d_wdata_i);
                chk("d_mem_strb",  mem_strb_o,  d_strb_i);
            end
        end

        eirv = 0;
        edrv = 0;
        erd  = '0;
        if (pending.size() > 0 && pending[0].due == cyc) begin
            if (pending[0].is_if) eirv = 1;
            else                  edrv = 1;
            erd = pending[0].data;
            void'(pending.pop_front());
        end
        chk("if_rvalid", if_rvalid_o, eirv);
        chk("d_rvalid",  d_rvalid_o,  edrv);
        if (eirv) last_if_rd = erd;
        if (edrv) last_d_rd  = erd;
        chk("if_rdata", if_rdata_o, last_if_rd);
        chk("d_rdata",  d_rdata_o,  last_d_rd);

        ridx = eig ? if_addr_i[8:2] : d_addr_i[8:2];
        if (eig || (edg && !d_we_i)) begin
            pending.push_back('{due: cyc + MEM_LAT, is_if: eig, data: ref_mem[ridx]});
            next_free = cyc + MEM_LAT;
        end else if (edg) begin
            for (int b = 0; b < STRB_W; b++)
                if (d_strb_i[b]) ref_mem[ridx][8*b +: 8] = d_wdata_i[8*b +: 8];
        end
        if (!if_req_i || eig)         losses = 0;
        else if (edg && losses < MAX_WAIT) losses = losses + 1;
        cyc++;
    endtask

    task automatic run_cycle();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; next_free = 0; losses = 0;
        last_if_rd = '0; last_d_rd = '0;
        for (int i = 0; i < 128; i++) ref_mem[i] = '0;
        ram_clr = 1'b1;

        // Reset with both requesters asking; data write of DEADBEEF to 0x100 wins first.
        reset = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h100;
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h100;
        d_wdata_i = 32'hDEADBEEF; d_strb_i = 4'hF;
        @(posedge clk); #1;
        ram_clr = 1'b0;
        run_cycle();
        run_cycle();
        reset = 1'b1;
        run_cycle();
        chk("t1_first_d_gnt",  obs_dg, 1);
        chk("t1_first_if_gnt", obs_ig, 0);

        // Fetch read of 0x100 with MEM_LAT=2, request held to probe T+1 and T+2.
        d_req_i = 1'b0;
        run_cycle();
        chk("t2_if_gnt_T", obs_ig, 1);
        if_addr_i = 32'h104;
        run_cycle();
        chk("t2_no_gnt_T1", obs_ig, 0);
        run_cycle();
        chk("t2_if_rvalid_T2", obs_irv, 1);
        chk("t2_if_rdata_T2",  obs_ird, 32'hDEADBEEF);
        chk("t2_regrant_T2",   obs_ig,  1);
        if_req_i = 1'b0;
        run_cycle();
        run_cycle();

        // Continuous data writes against a waiting fetch.
        if_req_i = 1'b1; if_addr_i = 32'h200;
        d_req_i = 1'b1; d_we_i = 1'b1; d_strb_i = 4'hF;
        for (int i = 0; i < MAX_WAIT; i++) begin
            d_addr_i = 32'h300 + 32'(4 * i); d_wdata_i = $urandom();
            run_cycle();
            chk("t3_d_wins", obs_dg, 1);
        end
        d_addr_i = 32'h310; d_wdata_i = 32'h12345678;
        run_cycle();
        chk("t3_if_forced", obs_ig, 1);
        chk("t3_d_held",    obs_dg, 0);
        if_req_i = 1'b0;
        run_cycle();
        chk("t3_wait_no_gnt", obs_dg, 0);
        run_cycle();
        chk("t3_d_resumes", obs_dg, 1);
        d_req_i = 1'b0;
        run_cycle();

        // Byte write then back-to-back writes.
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h40; d_wdata_i = 32'h0000_00AA; d_strb_i = 4'b0001;
        run_cycle();
        chk("t4_d_gnt",    obs_dg,   1);
        chk("t4_mem_we",   obs_we,   1);
        chk("t4_mem_strb", obs_strb, 4'b0001);
        for (int i = 1; i < 4; i++) begin
            d_addr_i = 32'h40 + 32'(4 * i); d_wdata_i = $urandom(); d_strb_i = 4'hF;
            run_cycle();
            chk("t4_b2b_gnt", obs_dg,  1);
            chk("t4_no_rvld", obs_drv, 0);
        end
        d_req_i = 1'b0;
        run_cycle();

        // Data read interrupted by reset: its return is dropped.
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h40;
        run_cycle();
        chk("t5_d_gnt", obs_dg, 1);
        d_req_i = 1'b0;
        reset = 1'b0;
        run_cycle();
        reset = 1'b1;
        run_cycle();
        chk("t5_no_rvalid_T2", obs_drv, 0);
        run_cycle();
        chk("t5_no_rvalid_T3", obs_drv, 0);
        d_req_i = 1'b1;
        run_cycle();
        chk("t5_regrant", obs_dg, 1);
        d_req_i = 1'b0;
        run_cycle();
        run_cycle();
        chk("t5_rvalid",   obs_drv, 1);
        chk("t5_rdata_aa", obs_drd, 32'h0000_00AA);

        // Fetch return coinciding with a new data-read grant.
        if_req_i = 1'b1; if_addr_i = 32'h100;
        run_cycle();
        chk("t6_if_gnt", obs_ig, 1);
        if_req_i = 1'b0;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h40;
        run_cycle();
        chk("t6_d_blocked", obs_dg, 0);
        run_cycle();
        chk("t6_if_rvalid", obs_irv, 1);
        chk("t6_d_gnt",     obs_dg,  1);
        d_req_i = 1'b0;
        run_cycle();
        run_cycle();
        chk("t6_d_rvalid", obs_drv, 1);
        chk("t6_d_rdata",  obs_drd, 32'h0000_00AA);

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 299) == 0) reset = 1'b0;
            if (!if_req_i || obs_ig) begin
                if_req_i  = ($urandom_range(0, 2) != 0);
                if_addr_i = $urandom() & ~32'h3;
            end
            if (!d_req_i || obs_dg) begin
                d_req_i   = ($urandom_range(0, 4) != 0);
                d_we_i    = $urandom_range(0, 1) != 0;
                d_addr_i  = $urandom() & ~32'h3;
                d_wdata_i = $urandom();
                d_strb_i  = 4'($urandom_range(0, 15));
            end
            run_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
